// File: rtl/ternary_hazard_scoreboard_pkg.sv
// ternary_hazard_scoreboard_pkg: shared sizes, trit/address types and address helpers
// Sizes live here so the interface, the bypass search and the scoreboard agree on them.
// trit_t encodes one balanced-ternary digit; an address holds REG_TRITS of them, [0] least significant.
package ternary_hazard_scoreboard_pkg;
    typedef enum logic [1:0] {T_ZERO = 2'b00, T_POS = 2'b01, T_NEG = 2'b10} trit_t;
    localparam int REG_TRITS = 3;
    localparam int NUM_REGS = 3 ** REG_TRITS;
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 3;
    localparam int MAX_LAT = 7;
    localparam int CNT_W = $clog2(MAX_LAT + 1);
    localparam int SEL_W = $clog2(NUM_FWD + 1);
    localparam int FWD_SEL_RF = 0;
    typedef logic [REG_TRITS-1:0][1:0] addr_t;
    function automatic logic is_r0_addr(addr_t a);
        logic r = 1'b1;
        for (int j = 0; j < REG_TRITS; j++) r &= (a[j] == T_ZERO);
        return r;
    endfunction
    // Each trit shifted to 0..2 and weighted 3**j, so R0 lands mid-range (13 for 3 trits).
    function automatic logic [IDX_W-1:0] trit_addr2idx(addr_t a);
        int s = 0;
        int w = 1;
        for (int j = 0; j < REG_TRITS; j++) begin
            s += (a[j] == T_NEG ? 0 : a[j] == T_POS ? 2 : 1) * w;
            w *= 3;
        end
        return IDX_W'(s);
    endfunction
endpackage

// File: rtl/ternary_hazard_scoreboard_if.sv
// ternary_hazard_scoreboard_if: ID/EX/bypass signals between the pipeline and the hazard unit
// Inputs to the unit: id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat, flush,
//   ex_rs, fwd_rd, fwd_we, fwd_rdy.
// Outputs from the unit: fwd_sel (0 = regfile, k+1 = bypass stage k), stall, sb_busy, stall_cnt.
interface ternary_hazard_scoreboard_if;
    import ternary_hazard_scoreboard_pkg::*;
    logic id_valid;
    addr_t [NUM_SRC-1:0] id_rs;
    logic [NUM_SRC-1:0] id_rs_used;
    addr_t id_rd;
    logic id_reg_write;
    logic [CNT_W-1:0] id_lat;
    logic flush;
    addr_t [NUM_SRC-1:0] ex_rs;
    addr_t [NUM_FWD-1:0] fwd_rd;
    logic [NUM_FWD-1:0] fwd_we;
    logic [NUM_FWD-1:0] fwd_rdy;
    logic [NUM_SRC-1:0][SEL_W-1:0] fwd_sel;
    logic stall;
    logic sb_busy;
    logic [15:0] stall_cnt;
    modport master (
        output id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat, flush,
        output ex_rs, fwd_rd, fwd_we, fwd_rdy,
        input fwd_sel, stall, sb_busy, stall_cnt
    );
    modport slave (
        input id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_lat, flush,
        input ex_rs, fwd_rd, fwd_we, fwd_rdy,
        output fwd_sel, stall, sb_busy, stall_cnt
    );
endinterface

// File: rtl/ternary_hazard_scoreboard_fwd_select.sv
// ternary_hazard_scoreboard_fwd_select: priority bypass search for one source operand
// rs      in   operand address
// fwd_rd  in   destination per bypass stage, [0] youngest
// fwd_we  in   stage writes its destination
// fwd_rdy in   stage's value is available
// sel     out  0 = regfile, k+1 = youngest matching stage k
// rdy     out  matched stage's rdy; 1 when nothing matches
module ternary_hazard_scoreboard_fwd_select
    import ternary_hazard_scoreboard_pkg::*;
(
    input  addr_t               rs,
    input  addr_t [NUM_FWD-1:0] fwd_rd,
    input  logic  [NUM_FWD-1:0] fwd_we,
    input  logic  [NUM_FWD-1:0] fwd_rdy,
    output logic  [SEL_W-1:0]   sel,
    output logic                rdy
);
    // Oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        sel = SEL_W'(FWD_SEL_RF);
        rdy = 1'b1;
        for (int k = NUM_FWD - 1; k >= 0; k--)
            if (fwd_we[k] && fwd_rd[k] == rs && !is_r0_addr(rs)) begin
                sel = SEL_W'(k + 1);
                rdy = fwd_rdy[k];
            end
    end
endmodule

// File: rtl/ternary_hazard_scoreboard.sv
// ternary_hazard_scoreboard: EX bypass selection, multi-cycle writer scoreboard and ID stall
// clk  in   clock
// rst  in   synchronous reset, active-high; clears scoreboard and stall counter
// io   slave side of ternary_hazard_scoreboard_if (ID/EX operands, bypass network, stall, status)
module ternary_hazard_scoreboard
    import ternary_hazard_scoreboard_pkg::*;
(
    input logic clk,
    input logic rst,
    ternary_hazard_scoreboard_if.slave io
);
    localparam logic [CNT_W:0] LAT_MAX = (CNT_W + 1)'(MAX_LAT);
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic [NUM_SRC-1:0][SEL_W-1:0] id_sel;
    logic [NUM_SRC-1:0] id_rdy;
    logic [NUM_SRC-1:0] ex_rdy;
    logic [CNT_W-1:0] lat_clip;
    logic [IDX_W-1:0] rd_idx;
    logic issue;
    logic load;
    genvar i;
    // The same search serves EX bypass selection and the ID load-use check.
    for (i = 0; i < NUM_SRC; i++) begin : g_src
        ternary_hazard_scoreboard_fwd_select u_ex (
            .rs(io.ex_rs[i]), .fwd_rd(io.fwd_rd), .fwd_we(io.fwd_we), .fwd_rdy(io.fwd_rdy),
            .sel(io.fwd_sel[i]), .rdy(ex_rdy[i])
        );
        ternary_hazard_scoreboard_fwd_select u_id (
            .rs(io.id_rs[i]), .fwd_rd(io.fwd_rd), .fwd_we(io.fwd_we), .fwd_rdy(io.fwd_rdy),
            .sel(id_sel[i]), .rdy(id_rdy[i])
        );
    end
    always_comb begin
        io.stall = io.id_valid && io.id_reg_write && !is_r0_addr(io.id_rd) && cnt[trit_addr2idx(io.id_rd)] != '0;
        for (int s = 0; s < NUM_SRC; s++)
            if (io.id_valid && io.id_rs_used[s] && !is_r0_addr(io.id_rs[s]))
                io.stall |= (id_sel[s] != SEL_W'(FWD_SEL_RF) && !id_rdy[s]) || cnt[trit_addr2idx(io.id_rs[s])] != '0;
    end
    always_comb begin
        io.sb_busy = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) io.sb_busy |= cnt[r] != '0;
    end
    assign rd_idx = trit_addr2idx(io.id_rd);
    assign lat_clip = {1'b0, io.id_lat} > LAT_MAX ? CNT_W'(MAX_LAT) : io.id_lat;
    assign issue = io.id_valid && !io.stall && !io.flush;
    assign load = issue && io.id_reg_write && io.id_lat != '0 && !is_r0_addr(io.id_rd);
    // A fresh load on an entry takes priority over that entry's decrement.
    always_ff @(posedge clk)
        for (int r = 0; r < NUM_REGS; r++)
            cnt[r] <= rst ? '0 : (load && rd_idx == IDX_W'(r)) ? lat_clip : cnt[r] - CNT_W'(cnt[r] != '0);
    always_ff @(posedge clk)
        io.stall_cnt <= rst ? '0 : io.stall_cnt + 16'(io.stall && io.stall_cnt != 16'hFFFF);
    a_lat_range: assert property (@(posedge clk) disable iff (rst)
        io.id_valid && io.id_reg_write |-> {1'b0, io.id_lat} <= LAT_MAX);
    // The load-use stall keeps a consumer in ID until its producer is ready, so EX never picks a pending value.
    a_ex_ready: assert property (@(posedge clk) disable iff (rst) &ex_rdy);
endmodule
